rx_ipv4: RTL and testbench

RX_IPV4 -- requirements
Module: rx_ipv4

---
 rtl/rx_ipv4.sv | 193 +++++++++++++++++++
 tb/tb_rx_ipv4.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ipv4.sv
// rx_ipv4: parses an IPv4 header from a byte stream and forwards the datagram payload.
// Define RX_IPV4_CSUM_EN to also verify the ones-complement header checksum.
//   state   | meaning
//   IDLE    | waiting for byte 0 of a new frame
//   HEADER  | capturing fixed header bytes 1-19
//   OPTIONS | skipping option bytes up to IHL*4-1
//   PAYLOAD | forwarding bytes below total length
//   DISCARD | ignoring the rest of the frame
module rx_ipv4 #(
    parameter int         OCT      = 8,
    parameter logic [3:0] IPV4_VER = 4'h4
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [31:0]    ip_addr,
    input  logic           rx_payload_ipv4,
    input  logic [OCT-1:0] rx_payload,
    output logic           rx_ip_valid,
    output logic [OCT-1:0] rx_ip_data,
    output logic [7:0]     rx_ip_protocol,
    output logic [31:0]    rx_ip_src,
    output logic           rx_ip_hdr_ok,
    output logic           rx_ip_drop
);

    typedef enum logic [2:0] {IDLE, HEADER, OPTIONS, PAYLOAD, DISCARD} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [3:0]  ver_r, ihl_r;
    logic [15:0] tot_len;
    logic        mf_r;
    logic [12:0] frag_off;
    logic [7:0]  proto_r;
    logic [31:0] src_r, dst_r;
    logic        armed;
    logic        hdr_ok_nxt, drop_nxt, fwd, start;
    logic        hdr_last, hdr_bad, csum_bad;
    logic [15:0] hdr_len;
    logic [16:0] cnt_p1;
    logic [31:0] dst_now;

    assign hdr_len = {10'd0, ihl_r, 2'b00};
    assign cnt_p1  = {1'b0, cnt} + 17'd1;
    // On byte 19 the last destination byte is still on the input bus.
    assign dst_now = (state == HEADER) ? {dst_r[23:0], rx_payload[7:0]} : dst_r;

`ifdef RX_IPV4_CSUM_EN
    logic [15:0] csum_r;
    logic [7:0]  csum_hi;
    logic [16:0] csum_add;
    logic [15:0] csum_now;

    assign csum_add = {1'b0, csum_r} + {1'b0, csum_hi, rx_payload[7:0]};
    assign csum_now = csum_add[15:0] + {15'd0, csum_add[16]};
    assign csum_bad = (csum_now != 16'hFFFF);

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            csum_r  <= '0;
            csum_hi <= '0;
        end else if (start) begin
            csum_r  <= '0;
            csum_hi <= rx_payload[7:0];
        end else if ((state == HEADER || state == OPTIONS) && rx_payload_ipv4) begin
            if (cnt[0]) csum_r <= csum_now;
            else        csum_hi <= rx_payload[7:0];
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

    assign hdr_last = rx_payload_ipv4 &&
                      ((state == HEADER && cnt == 16'd19 && ihl_r <= 4'd5) ||
                       (state == OPTIONS && cnt == hdr_len - 16'd1));

    assign hdr_bad = (ver_r != IPV4_VER) || (ihl_r < 4'd5) || (tot_len < hdr_len) ||
                     mf_r || (frag_off != 13'd0) ||
                     ((dst_now != ip_addr) && (dst_now != 32'hFFFF_FFFF)) || csum_bad;

    always_comb begin
        state_nxt  = state;
        hdr_ok_nxt = 1'b0;
        drop_nxt   = 1'b0;
        fwd        = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_payload_ipv4 && armed) begin
                    start     = 1'b1;
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (!rx_payload_ipv4) begin
                    drop_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == 16'd19 && ihl_r > 4'd5) begin
                    state_nxt = OPTIONS;
                end
            end
            OPTIONS: begin
                if (!rx_payload_ipv4) begin
                    drop_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PAYLOAD: begin
                if (!rx_payload_ipv4) begin
                    drop_nxt  = (cnt < tot_len);
                    state_nxt = IDLE;
                end else begin
                    fwd = (cnt < tot_len);
                    if (cnt_p1 >= {1'b0, tot_len}) state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (!rx_payload_ipv4) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (hdr_last) begin
            if (hdr_bad) begin
                drop_nxt  = 1'b1;
                state_nxt = DISCARD;
            end else begin
                hdr_ok_nxt = 1'b1;
                state_nxt  = PAYLOAD;
            end
        end
    end

    // armed requires a low cycle before byte 0, so a frame cut by reset is not re-parsed.
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            armed    <= 1'b0;
            ver_r    <= '0;
            ihl_r    <= '0;
            tot_len  <= '0;
            mf_r     <= 1'b0;
            frag_off <= '0;
            proto_r  <= '0;
            src_r    <= '0;
            dst_r    <= '0;
        end else begin
            state <= state_nxt;
            armed <= !rx_payload_ipv4;
            if (start) begin
                cnt   <= 16'd1;
                ver_r <= rx_payload[7:4];
                ihl_r <= rx_payload[3:0];
            end else if (rx_payload_ipv4 && (state == HEADER || state == OPTIONS || state == PAYLOAD)) begin
                cnt <= cnt + 16'd1;
            end
            if (state == HEADER && rx_payload_ipv4) begin
                case (cnt)
                    16'd2:  tot_len[15:8]  <= rx_payload[7:0];
                    16'd3:  tot_len[7:0]   <= rx_payload[7:0];
                    16'd6:  {mf_r, frag_off[12:8]} <= rx_payload[5:0];
                    16'd7:  frag_off[7:0]  <= rx_payload[7:0];
                    16'd9:  proto_r        <= rx_payload[7:0];
                    16'd12, 16'd13, 16'd14, 16'd15: src_r <= {src_r[23:0], rx_payload[7:0]};
                    16'd16, 16'd17, 16'd18, 16'd19: dst_r <= {dst_r[23:0], rx_payload[7:0]};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            rx_ip_valid    <= 1'b0;
            rx_ip_data     <= '0;
            rx_ip_protocol <= '0;
            rx_ip_src      <= '0;
            rx_ip_hdr_ok   <= 1'b0;
            rx_ip_drop     <= 1'b0;
        end else begin
            rx_ip_valid  <= fwd;
            rx_ip_hdr_ok <= hdr_ok_nxt;
            rx_ip_drop   <= drop_nxt;
            if (fwd) rx_ip_data <= rx_payload;
            if (hdr_ok_nxt) begin
                rx_ip_protocol <= proto_r;
                rx_ip_src      <= src_r;
            end
        end
    end

endmodule

// File: tb/tb_rx_ipv4.sv
// Randomized scoreboard bench for rx_ipv4; a datagram-level model predicts every output event.
module tb_rx_ipv4;

    localparam logic [31:0] IP = 32'h0A00_0002;

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic [31:0] ip_addr;
    logic        rx_payload_ipv4;
    logic [7:0]  rx_payload;
    logic        rx_ip_valid;
    logic [7:0]  rx_ip_data;
    logic [7:0]  rx_ip_protocol;
    logic [31:0] rx_ip_src;
    logic        rx_ip_hdr_ok;
    logic        rx_ip_drop;

    rx_ipv4 #(.OCT(8), .IPV4_VER(4'h4)) dut (
        .RX_CLK(RX_CLK), .rst(rst), .ip_addr(ip_addr),
        .rx_payload_ipv4(rx_payload_ipv4), .rx_payload(rx_payload),
        .rx_ip_valid(rx_ip_valid), .rx_ip_data(rx_ip_data),
        .rx_ip_protocol(rx_ip_protocol), .rx_ip_src(rx_ip_src),
        .rx_ip_hdr_ok(rx_ip_hdr_ok), .rx_ip_drop(rx_ip_drop)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct {
        int          kind;   // 0 hdr_ok, 1 data, 2 drop
        int          cyc;
        logic [7:0]  data;
        logic [7:0]  proto;
        logic [31:0] src;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] fr[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(posedge RX_CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [7:0] d,
                        input logic [7:0] p, input logic [31:0] s);
        ev_t e;
        e.kind = kind; e.cyc = c; e.data = d; e.proto = p; e.src = s;
        sb.push_back(e);
    endtask

    function automatic int ones_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i += 2) begin
            s = s + int'(fr[i]) * 256 + int'(fr[i+1]);
            s = (s & 32'hFFFF) + (s >>> 16);
        end
        return s;
    endfunction

    task automatic build(input int ver, input int ihl, input int tl, input int mf, input int off,
                         input int proto, input logic [31:0] dst, input int flen, input int cerr);
        logic [31:0] src;
        int n, c;
        src = $urandom;
        fr.delete();
        for (int i = 0; i < flen; i++) fr.push_back(8'($urandom));
        fr[0] = 8'(ver * 16 + ihl);
        fr[1] = 8'h00;
        fr[2] = 8'(tl / 256);  fr[3] = 8'(tl % 256);
        fr[6] = 8'(mf * 32 + off / 256); fr[7] = 8'(off % 256);
        fr[8] = 8'd64;         fr[9] = 8'(proto);
        fr[10] = 8'h00;        fr[11] = 8'h00;
        fr[12] = src[31:24]; fr[13] = src[23:16]; fr[14] = src[15:8]; fr[15] = src[7:0];
        fr[16] = dst[31:24]; fr[17] = dst[23:16]; fr[18] = dst[15:8]; fr[19] = dst[7:0];
        n = (ihl <= 5) ? 20 : ihl * 4;
        c = ((~ones_sum(n) & 32'hFFFF) + cerr) & 32'hFFFF;
        fr[10] = 8'(c / 256);  fr[11] = 8'(c % 256);
    endtask

    // Expected events for frame fr, byte 0 in cycle c0, first `sent` bytes delivered.
    task automatic model(input int c0, input int sent);
        int ver, ihl, hl, tl, mf, off, lastidx;
        logic [31:0] dst, src;
        bit bad;
        ver = int'(fr[0]) / 16;
        ihl = int'(fr[0]) % 16;
        hl  = ihl * 4;
        tl  = int'(fr[2]) * 256 + int'(fr[3]);
        mf  = int'(fr[6][5]);
        off = int'(fr[6][4:0]) * 256 + int'(fr[7]);
        src = {fr[12], fr[13], fr[14], fr[15]};
        dst = {fr[16], fr[17], fr[18], fr[19]};
        lastidx = (ihl <= 5) ? 19 : hl - 1;
        if (sent <= lastidx) begin
            push(2, c0 + sent + 1, 8'h00, 8'h00, 32'h0);
            return;
        end
        bad = (ver != 4) || (ihl < 5) || (tl < hl) || (mf != 0) || (off != 0) ||
              (dst != IP && dst != 32'hFFFF_FFFF);
`ifdef RX_IPV4_CSUM_EN
        if (ones_sum(lastidx + 1) != 32'hFFFF) bad = 1'b1;
`endif
        if (bad) begin
            push(2, c0 + lastidx + 1, 8'h00, 8'h00, 32'h0);
            return;
        end
        push(0, c0 + lastidx + 1, 8'h00, fr[9], src);
        for (int n = hl; n < tl && n < sent; n++) push(1, c0 + n + 1, fr[n], 8'h00, 32'h0);
        if (sent < tl) push(2, c0 + sent + 1, 8'h00, 8'h00, 32'h0);
    endtask

    task automatic send(input int sent, input int gap);
        int c0;
        @(posedge RX_CLK); #1;
        c0 = cyc;
        model(c0, sent);
        for (int i = 0; i < sent; i++) begin
            rx_payload_ipv4 = 1'b1;
            rx_payload      = fr[i];
            @(posedge RX_CLK); #1;
        end
        rx_payload_ipv4 = 1'b0;
        rx_payload      = 8'($urandom);
        repeat (gap) @(posedge RX_CLK);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_valid"},  32'(rx_ip_valid),    32'h0);
        chk({tag, "_data"},   32'(rx_ip_data),     32'h0);
        chk({tag, "_proto"},  32'(rx_ip_protocol), 32'h0);
        chk({tag, "_src"},    rx_ip_src,           32'h0);
        chk({tag, "_hdr_ok"}, 32'(rx_ip_hdr_ok),   32'h0);
        chk({tag, "_drop"},   32'(rx_ip_drop),     32'h0);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event kind=%0d at cyc=%0d, expected no event", kind, cyc);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            fails++;
            $display("FAIL event_order got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                     kind, cyc, e.kind, e.cyc);
        end else if (kind == 0 && (rx_ip_protocol != e.proto || rx_ip_src != e.src)) begin
            fails++;
            $display("FAIL hdr_fields got proto=%0h src=%0h expected proto=%0h src=%0h",
                     rx_ip_protocol, rx_ip_src, e.proto, e.src);
        end else if (kind == 1 && rx_ip_data != e.data) begin
            fails++;
            $display("FAIL payload_data cyc=%0d got=%0h expected=%0h", cyc, rx_ip_data, e.data);
        end
        if (kind == 1) last_data = e.data;
    endtask

    always @(negedge RX_CLK) begin
        if (mon_en) begin
            if (rx_ip_hdr_ok && rx_ip_drop) begin
                tests++; fails++;
                $display("FAIL both_pulses cyc=%0d got hdr_ok=1 drop=1 expected at most one", cyc);
            end
            if (rx_ip_hdr_ok) check_ev(0);
            if (rx_ip_drop)   check_ev(2);
            if (rx_ip_valid)  check_ev(1);
            else begin
                tests++;
                if (rx_ip_data != last_data) begin
                    fails++;
                    $display("FAIL data_hold cyc=%0d got=%0h expected=%0h", cyc, rx_ip_data, last_data);
                end
            end
            if (rst) last_data = 8'h00;
        end
    end

    task automatic reset_test();
        int c0;
        build(4, 5, 28, 0, 0, 8'h11, IP, 46, 0);
        @(posedge RX_CLK); #1;
        c0 = cyc;
        push(0, c0 + 20, 8'h00, fr[9], {fr[12], fr[13], fr[14], fr[15]});
        for (int n = 20; n < 25; n++) push(1, c0 + n + 1, fr[n], 8'h00, 32'h0);
        for (int i = 0; i < 46; i++) begin
            rx_payload_ipv4 = 1'b1;
            rx_payload      = fr[i];
            rst             = (i == 25);
            @(posedge RX_CLK); #1;
            if (i == 25) zero_chk("mid_reset");
        end
        rst = 1'b0;
        rx_payload_ipv4 = 1'b0;
        repeat (2) @(posedge RX_CLK);
    endtask

    initial begin
        rst = 1'b1;
        ip_addr = IP;
        rx_payload_ipv4 = 1'b0;
        rx_payload = 8'h00;
        repeat (3) @(posedge RX_CLK);
        #1;
        zero_chk("reset");
        mon_en = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge RX_CLK);

        build(4, 5, 28, 0, 0, 8'h11, IP, 46, 0);              send(46, 2);
        chk("udp_protocol", 32'(rx_ip_protocol), 32'h11);
        build(4, 5, 28, 0, 0, 8'h11, 32'h0A00_0063, 46, 0);   send(46, 2);
        build(4, 5, 28, 0, 0, 8'h11, 32'hFFFF_FFFF, 46, 0);   send(46, 2);
        build(4, 6, 32, 0, 0, 8'h06, IP, 46, 0);              send(46, 1);
        build(4, 5, 28, 0, 0, 8'h11, IP, 46, 1);              send(46, 1);
        build(4, 5, 28, 0, 0, 8'h11, IP, 46, 0);              send(11, 1);
        build(4, 5, 28, 0, 0, 8'h11, IP, 46, 0);              send(46, 1);
        build(4, 5, 20, 0, 0, 8'h01, IP, 46, 0);              send(46, 1);
        build(6, 5, 28, 0, 0, 8'h11, IP, 46, 0);              send(46, 1);
        build(4, 5, 28, 1, 0, 8'h11, IP, 46, 0);              send(46, 1);
        build(4, 5, 28, 0, 185, 8'h11, IP, 46, 0);            send(46, 1);
        build(4, 6, 22, 0, 0, 8'h11, IP, 46, 0);              send(46, 1);
        build(4, 4, 28, 0, 0, 8'h11, IP, 46, 0);              send(46, 1);
        build(4, 5, 60, 0, 0, 8'h11, IP, 60, 0);              send(40, 1);
        build(4, 5, 50, 0, 0, 8'h11, IP, 50, 0);              send(50, 1);

        reset_test();
        build(4, 5, 28, 0, 0, 8'h11, IP, 46, 0);              send(46, 2);

        for (int k = 0; k < 40; k++) begin
            int ihl, hl, tl, flen, sent, m, ver, mf, off, cerr;
            logic [31:0] dst;
            ihl = (int'($urandom_range(0, 3)) == 0) ? int'($urandom_range(6, 8)) : 5;
            hl  = ihl * 4;
            tl  = hl + int'($urandom_range(0, 24));
            flen = ((tl < 46) ? 46 : tl) + int'($urandom_range(0, 3));
            ver = 4; mf = 0; off = 0; cerr = 0; dst = IP; sent = flen;
            m = int'($urandom_range(0, 11));
            case (m)
                0: dst = 32'h0A00_0063;
                1: dst = 32'hFFFF_FFFF;
                2: ver = 6;
                3: mf = 1;
                4: off = int'($urandom_range(1, 8191));
                5: cerr = 1;
                6: sent = int'($urandom_range(1, tl - 1));
                7: tl = hl - 2;
                default: ;
            endcase
            build(ver, ihl, tl, mf, off, int'($urandom_range(0, 255)), dst, flen, cerr);
            send(sent, int'($urandom_range(1, 3)));
        end

        repeat (10) @(posedge RX_CLK);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
